// File: rtl/debug_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing the UART TX FIFO write port between two byte streamers.
// Optional packet counters are enabled by defining ARB_PACKET_COUNT_EN.
module debug_tx_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0Valid,
    input  logic [DATA_WIDTH-1:0] req0Data,
    input  logic                  req0Last,
    output logic                  req0Ready,
    input  logic                  req1Valid,
    input  logic [DATA_WIDTH-1:0] req1Data,
    input  logic                  req1Last,
    output logic                  req1Ready,
    input  logic                  fifoAlmostFull,
    output logic [DATA_WIDTH-1:0] dataToUartOutFifo,
    output logic                  writeFifoFlag,
    output logic [1:0]            grant,
    output logic                  timeoutPulse,
    output logic [7:0]            packetCount0,
    output logic [7:0]            packetCount1
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                state, state_next;
    logic                  last_served, last_served_next;
    logic [CW-1:0]         idle_cnt, idle_cnt_next, idle_cnt_inc;
    logic                  owner_valid, owner_last, accept, idle_tick, timeout;
    logic [DATA_WIDTH-1:0] owner_data;

    // Datapath view of whichever requester currently owns the port.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        req0Ready   = 1'b0;
        req1Ready   = 1'b0;
        case (state)
            OWN0: begin
                owner_valid = req0Valid;
                owner_last  = req0Last;
                owner_data  = req0Data;
                req0Ready   = !fifoAlmostFull;
            end
            OWN1: begin
                owner_valid = req1Valid;
                owner_last  = req1Last;
                owner_data  = req1Data;
                req1Ready   = !fifoAlmostFull;
            end
            default: ;
        endcase
        accept       = owner_valid && !fifoAlmostFull;
        // Only a silent owner counts; stalls under backpressure never time out.
        idle_tick    = (state != IDLE) && !owner_valid;
        idle_cnt_inc = idle_cnt + CW'(1);
        timeout      = idle_tick && (idle_cnt_inc == CW'(TIMEOUT_CYCLES));
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next       = state;
        last_served_next = last_served;
        idle_cnt_next    = idle_cnt;
        case (state)
            IDLE: begin
                idle_cnt_next = '0;
                if (req0Valid && (!req1Valid || last_served))
                    state_next = OWN0;
                else if (req1Valid)
                    state_next = OWN1;
            end
            OWN0, OWN1: begin
                if (accept) begin
                    idle_cnt_next = '0;
                    if (owner_last) begin
                        state_next       = IDLE;
                        last_served_next = (state == OWN1);
                    end
                end else if (timeout) begin
                    idle_cnt_next    = '0;
                    state_next       = IDLE;
                    last_served_next = (state == OWN1);
                end else if (idle_tick) begin
                    idle_cnt_next = idle_cnt_inc;
                end
            end
            default: begin
                state_next    = IDLE;
                idle_cnt_next = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            last_served       <= 1'b1;
            idle_cnt          <= '0;
            writeFifoFlag     <= 1'b0;
            dataToUartOutFifo <= '0;
        end else begin
            state         <= state_next;
            last_served   <= last_served_next;
            idle_cnt      <= idle_cnt_next;
            writeFifoFlag <= accept;
            if (accept)
                dataToUartOutFifo <= owner_data;
        end
    end

    assign grant        = {state == OWN1, state == OWN0};
    assign timeoutPulse = timeout;

`ifdef ARB_PACKET_COUNT_EN
    logic [7:0] pkt_cnt0, pkt_cnt1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (accept && owner_last) begin
            if (state == OWN0)
                pkt_cnt0 <= pkt_cnt0 + 8'd1;
            else
                pkt_cnt1 <= pkt_cnt1 + 8'd1;
        end
    end

    assign packetCount0 = pkt_cnt0;
    assign packetCount1 = pkt_cnt1;
`else
    assign packetCount0 = '0;
    assign packetCount1 = '0;
`endif

endmodule
